// File: rtl/tc_writeback_pkg.sv
// Shared constants for the TotalCoeff writeback path: block index map, fill lengths, FSM encodings.
// Purely declarative; no latency or backpressure of its own.
package tc_writeback_pkg;

  localparam logic [5:0] LUMA_BASE   = 6'd0;
  localparam logic [5:0] CB_BASE     = 6'd18;
  localparam logic [5:0] CR_BASE     = 6'd34;
  localparam logic [5:0] DC_LUMA_IDX = 6'd63;
  localparam logic [5:0] DC_CB_IDX   = 6'd16;
  localparam logic [5:0] DC_CR_IDX   = 6'd17;
  localparam logic [5:0] END_IDX     = 6'd49;

  localparam logic [5:0] FILL_LEN_MB = 6'd48;
  localparam logic [5:0] FILL_LEN_B8 = 6'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  typedef enum logic {
    FILL_MB = 1'b0,
    FILL_B8 = 1'b1
  } fill_mode_t;

  // DC codes have no TotalCoeff slot in either RAM; 50..62 are unused codes.
  function automatic logic is_blk_idx(input logic [5:0] idx);
    return (idx != DC_LUMA_IDX) && (idx != DC_CB_IDX) && (idx != DC_CR_IDX) && (idx <= END_IDX);
  endfunction

endpackage

// File: rtl/tc_writeback_if.sv
// CAVLC-side requests into the writeback block and the shared A/B TotalCoeff RAM write port.
// master = upstream driver, slave = tc_writeback.
interface tc_writeback_if;
  logic       tc_valid;
  logic [4:0] TotalCoeff;
  logic       res_0;
  logic [5:0] blk_idx;
  logic [7:0] mb_num_h;
  logic       blk8_zero_req;
  logic [1:0] blk8_idx;
  logic       mb_zero_req;
  logic       TC_wr_n;
  logic [5:0] TC_A_wr_addr;
  logic [12:0] TC_B_wr_addr;
  logic [4:0] TC_din;
  logic       busy;
  logic       fill_done;

  modport master (
    output tc_valid, TotalCoeff, res_0, blk_idx, mb_num_h, blk8_zero_req, blk8_idx, mb_zero_req,
    input  TC_wr_n, TC_A_wr_addr, TC_B_wr_addr, TC_din, busy, fill_done
  );

  modport slave (
    input  tc_valid, TotalCoeff, res_0, blk_idx, mb_num_h, blk8_zero_req, blk8_idx, mb_zero_req,
    output TC_wr_n, TC_A_wr_addr, TC_B_wr_addr, TC_din, busy, fill_done
  );
endinterface

// File: rtl/tc_fill_idx_gen.sv
// Maps (fill mode, quadrant, counter) to the block index of the zero-fill write; combinational, 0 cycles.
// No backpressure: the caller owns sequencing.
module tc_fill_idx_gen
  import tc_writeback_pkg::*;
(
  input  fill_mode_t  i_mode,
  input  logic [1:0]  i_quad,
  input  logic [5:0]  i_cnt,
  output logic [5:0]  o_idx
);

  logic [5:0] w_base;

  always_comb begin
    w_base = LUMA_BASE;
    o_idx  = '0;
    if (i_mode == FILL_MB) begin
      // 16 entries per plane: counter bits [5:4] pick the plane.
      case (i_cnt[5:4])
        2'd0:    w_base = LUMA_BASE;
        2'd1:    w_base = CB_BASE;
        default: w_base = CR_BASE;
      endcase
      o_idx = w_base + {2'b00, i_cnt[3:0]};
    end else begin
      // 4 entries per plane: counter bits [3:2] pick the plane, quadrant selects the group of 4.
      case (i_cnt[3:2])
        2'd0:    w_base = LUMA_BASE;
        2'd1:    w_base = CB_BASE;
        default: w_base = CR_BASE;
      endcase
      o_idx = w_base + {2'b00, i_quad, i_cnt[1:0]};
    end
  end

endmodule

// File: rtl/tc_writeback.sv
// Writes block TotalCoeff (or zero-fills uncoded quadrants/MBs) into the A and B nC RAMs; 1-cycle registered latency.
// No backpressure: tc_valid arriving during a fill waits in a one-entry skid and drains right after the last fill write.
module tc_writeback
  import tc_writeback_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  tc_writeback_if.slave  tif
);

  state_t      r_state, w_state_nxt;
  fill_mode_t  r_mode, w_mode_nxt;
  logic [1:0]  r_quad, w_quad_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [6:0]  r_mbh, w_mbh_nxt;

  logic        r_skid_vld, w_skid_vld_nxt;
  logic [5:0]  r_skid_idx, w_skid_idx_nxt;
  logic [4:0]  r_skid_din, w_skid_din_nxt;
  logic [6:0]  r_skid_mbh, w_skid_mbh_nxt;

  logic        r_wr_n, w_wr_n_nxt;
  logic [5:0]  r_a_addr, w_a_addr_nxt;
  logic [12:0] r_b_addr, w_b_addr_nxt;
  logic [4:0]  r_din, w_din_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_fill_done, w_fill_done_nxt;

  fill_mode_t  w_gen_mode;
  logic [1:0]  w_gen_quad;
  logic [5:0]  w_gen_cnt;
  logic [5:0]  w_gen_idx;

  logic        w_tc_ok;
  logic [4:0]  w_tc_din;
  logic        w_fill_last;
  logic        w_unused_ok;

  assign w_tc_ok     = tif.tc_valid && is_blk_idx(tif.blk_idx);
  assign w_tc_din    = tif.res_0 ? 5'd0 : tif.TotalCoeff;
  assign w_fill_last = (r_cnt == (((r_mode == FILL_MB) ? FILL_LEN_MB : FILL_LEN_B8) - 6'd1));
  assign w_unused_ok = tif.mb_num_h[7];

  tc_fill_idx_gen u_idx_gen (
    .i_mode (w_gen_mode),
    .i_quad (w_gen_quad),
    .i_cnt  (w_gen_cnt),
    .o_idx  (w_gen_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_quad_nxt      = r_quad;
    w_cnt_nxt       = r_cnt;
    w_mbh_nxt       = r_mbh;
    w_skid_vld_nxt  = r_skid_vld;
    w_skid_idx_nxt  = r_skid_idx;
    w_skid_din_nxt  = r_skid_din;
    w_skid_mbh_nxt  = r_skid_mbh;
    w_wr_n_nxt      = 1'b1;
    w_a_addr_nxt    = '0;
    w_b_addr_nxt    = '0;
    w_din_nxt       = '0;
    w_busy_nxt      = 1'b0;
    w_fill_done_nxt = 1'b0;
    w_gen_mode      = r_mode;
    w_gen_quad      = r_quad;
    w_gen_cnt       = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (tif.mb_zero_req || tif.blk8_zero_req) begin
          w_state_nxt  = ST_FILL;
          w_mode_nxt   = tif.mb_zero_req ? FILL_MB : FILL_B8;
          w_quad_nxt   = tif.blk8_idx;
          w_mbh_nxt    = tif.mb_num_h[6:0];
          w_cnt_nxt    = 6'd1;
          w_busy_nxt   = 1'b1;
          // First fill write goes out on the next edge, so index it from the request itself.
          w_gen_mode   = w_mode_nxt;
          w_gen_quad   = w_quad_nxt;
          w_gen_cnt    = 6'd0;
          w_wr_n_nxt   = 1'b0;
          w_a_addr_nxt = w_gen_idx;
          w_b_addr_nxt = {tif.mb_num_h[6:0], w_gen_idx};
          if (w_tc_ok) begin
            w_skid_vld_nxt = 1'b1;
            w_skid_idx_nxt = tif.blk_idx;
            w_skid_din_nxt = w_tc_din;
            w_skid_mbh_nxt = tif.mb_num_h[6:0];
          end
        end else if (r_skid_vld) begin
          w_wr_n_nxt     = 1'b0;
          w_a_addr_nxt   = r_skid_idx;
          w_b_addr_nxt   = {r_skid_mbh, r_skid_idx};
          w_din_nxt      = r_skid_din;
          w_skid_vld_nxt = w_tc_ok;
          if (w_tc_ok) begin
            w_skid_idx_nxt = tif.blk_idx;
            w_skid_din_nxt = w_tc_din;
            w_skid_mbh_nxt = tif.mb_num_h[6:0];
          end
        end else if (w_tc_ok) begin
          w_wr_n_nxt   = 1'b0;
          w_a_addr_nxt = tif.blk_idx;
          w_b_addr_nxt = {tif.mb_num_h[6:0], tif.blk_idx};
          w_din_nxt    = w_tc_din;
        end
      end

      ST_FILL: begin
        w_wr_n_nxt   = 1'b0;
        w_a_addr_nxt = w_gen_idx;
        w_b_addr_nxt = {r_mbh, w_gen_idx};
        w_busy_nxt   = 1'b1;
        if (w_tc_ok) begin
          w_skid_vld_nxt = 1'b1;
          w_skid_idx_nxt = tif.blk_idx;
          w_skid_din_nxt = w_tc_din;
          w_skid_mbh_nxt = tif.mb_num_h[6:0];
        end
        if (w_fill_last) begin
          w_cnt_nxt       = 6'd0;
          w_fill_done_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= FILL_MB;
      r_quad      <= '0;
      r_cnt       <= '0;
      r_mbh       <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_idx  <= '0;
      r_skid_din  <= '0;
      r_skid_mbh  <= '0;
      r_wr_n      <= 1'b1;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_din       <= '0;
      r_busy      <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_quad      <= w_quad_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mbh       <= w_mbh_nxt;
      r_skid_vld  <= w_skid_vld_nxt;
      r_skid_idx  <= w_skid_idx_nxt;
      r_skid_din  <= w_skid_din_nxt;
      r_skid_mbh  <= w_skid_mbh_nxt;
      r_wr_n      <= w_wr_n_nxt;
      r_a_addr    <= w_a_addr_nxt;
      r_b_addr    <= w_b_addr_nxt;
      r_din       <= w_din_nxt;
      r_busy      <= w_busy_nxt;
      r_fill_done <= w_fill_done_nxt;
    end
  end

  assign tif.TC_wr_n      = r_wr_n;
  assign tif.TC_A_wr_addr = r_a_addr;
  assign tif.TC_B_wr_addr = r_b_addr;
  assign tif.TC_din       = r_din;
  assign tif.busy         = r_busy;
  assign tif.fill_done    = r_fill_done;

endmodule

// File: tb/tb_tc_writeback.sv
// Directed bench for tc_writeback: vector table for single block writes, hand sequences for fills, skid and reset.
module tb_tc_writeback;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tc_writeback_if tif();

  tc_writeback dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tif     (tif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [5:0]  idx;
    logic [4:0]  tc;
    logic        res0;
    logic [7:0]  mbh;
    logic        exp_wr_n;
    logic [5:0]  exp_a;
    logic [12:0] exp_b;
    logic [4:0]  exp_din;
  } vec_t;

  vec_t vecs[12];

  task automatic check_outputs_idle(input string tag);
    chk({tag, "_wr_n"}, 32'(tif.TC_wr_n), 32'd1);
    chk({tag, "_a"}, 32'(tif.TC_A_wr_addr), 32'd0);
    chk({tag, "_b"}, 32'(tif.TC_B_wr_addr), 32'd0);
    chk({tag, "_din"}, 32'(tif.TC_din), 32'd0);
    chk({tag, "_busy"}, 32'(tif.busy), 32'd0);
    chk({tag, "_done"}, 32'(tif.fill_done), 32'd0);
  endtask

  task automatic run_fill(input string tag, input logic is_mb, input logic both, input logic [1:0] q,
                          input logic [7:0] mbh, input int skid_k, input logic [5:0] skid_idx,
                          input logic [4:0] skid_tc);
    int exp_idx[$];
    int base[3] = '{0, 18, 34};
    int n;
    logic [5:0] ei;
    for (int p = 0; p < 3; p++) begin
      if (is_mb) for (int j = 0; j < 16; j++) exp_idx.push_back(base[p] + j);
      else       for (int j = 0; j < 4; j++)  exp_idx.push_back(base[p] + 4 * int'(q) + j);
    end
    n = exp_idx.size();

    @(negedge clk);
    tif.mb_num_h      = mbh;
    tif.blk8_idx      = q;
    tif.mb_zero_req   = is_mb;
    tif.blk8_zero_req = !is_mb || both;
    @(posedge clk); #1;
    tif.mb_zero_req   = 1'b0;
    tif.blk8_zero_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      ei = 6'(exp_idx[k]);
      chk($sformatf("%s_wr_n[%0d]", tag, k), 32'(tif.TC_wr_n), 32'd0);
      chk($sformatf("%s_a[%0d]", tag, k), 32'(tif.TC_A_wr_addr), 32'(ei));
      chk($sformatf("%s_b[%0d]", tag, k), 32'(tif.TC_B_wr_addr), 32'({mbh[6:0], ei}));
      chk($sformatf("%s_din[%0d]", tag, k), 32'(tif.TC_din), 32'd0);
      chk($sformatf("%s_busy[%0d]", tag, k), 32'(tif.busy), 32'd1);
      chk($sformatf("%s_done[%0d]", tag, k), 32'(tif.fill_done), 32'(k == n - 1));
      tif.tc_valid   = (k == skid_k);
      tif.blk_idx    = skid_idx;
      tif.TotalCoeff = skid_tc;
      tif.res_0      = 1'b0;
    end
    tif.tc_valid = 1'b0;
    @(posedge clk); #1;
    if (skid_k >= 0) begin
      chk({tag, "_skid_wr_n"}, 32'(tif.TC_wr_n), 32'd0);
      chk({tag, "_skid_a"}, 32'(tif.TC_A_wr_addr), 32'(skid_idx));
      chk({tag, "_skid_b"}, 32'(tif.TC_B_wr_addr), 32'({mbh[6:0], skid_idx}));
      chk({tag, "_skid_din"}, 32'(tif.TC_din), 32'(skid_tc));
      chk({tag, "_skid_busy"}, 32'(tif.busy), 32'd0);
      @(posedge clk); #1;
    end
    check_outputs_idle({tag, "_after"});
  endtask

  initial begin
    tif.tc_valid = 1'b0; tif.TotalCoeff = '0; tif.res_0 = 1'b0; tif.blk_idx = '0;
    tif.mb_num_h = '0; tif.blk8_zero_req = 1'b0; tif.blk8_idx = '0; tif.mb_zero_req = 1'b0;

    vecs[0]  = '{1'b1, 6'd5,  5'd7,  1'b0, 8'd3,   1'b0, 6'd5,  13'h0C5,  5'd7};
    vecs[1]  = '{1'b1, 6'd20, 5'd9,  1'b1, 8'd3,   1'b0, 6'd20, 13'h0D4,  5'd0};
    vecs[2]  = '{1'b1, 6'd63, 5'd4,  1'b0, 8'd3,   1'b1, 6'd0,  13'h000,  5'd0};
    vecs[3]  = '{1'b1, 6'd16, 5'd4,  1'b0, 8'd3,   1'b1, 6'd0,  13'h000,  5'd0};
    vecs[4]  = '{1'b1, 6'd17, 5'd4,  1'b0, 8'd3,   1'b1, 6'd0,  13'h000,  5'd0};
    vecs[5]  = '{1'b1, 6'd49, 5'd16, 1'b0, 8'd255, 1'b0, 6'd49, 13'h1FF1, 5'd16};
    vecs[6]  = '{1'b1, 6'd0,  5'd1,  1'b0, 8'd0,   1'b0, 6'd0,  13'h000,  5'd1};
    vecs[7]  = '{1'b1, 6'd15, 5'd2,  1'b0, 8'd1,   1'b0, 6'd15, 13'h04F,  5'd2};
    vecs[8]  = '{1'b1, 6'd18, 5'd4,  1'b0, 8'd5,   1'b0, 6'd18, 13'h152,  5'd4};
    vecs[9]  = '{1'b1, 6'd34, 5'd11, 1'b0, 8'd10,  1'b0, 6'd34, 13'h2A2,  5'd11};
    vecs[10] = '{1'b0, 6'd33, 5'd5,  1'b0, 8'd10,  1'b1, 6'd0,  13'h000,  5'd0};
    vecs[11] = '{1'b1, 6'd33, 5'd0,  1'b0, 8'd128, 1'b0, 6'd33, 13'h021,  5'd0};

    repeat (2) @(posedge clk);
    #1;
    check_outputs_idle("rst_in");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_idle("rst_out");

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tif.tc_valid   = vecs[i].vld;
      tif.blk_idx    = vecs[i].idx;
      tif.TotalCoeff = vecs[i].tc;
      tif.res_0      = vecs[i].res0;
      tif.mb_num_h   = vecs[i].mbh;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wr_n", i), 32'(tif.TC_wr_n), 32'(vecs[i].exp_wr_n));
      chk($sformatf("vec%0d_a", i), 32'(tif.TC_A_wr_addr), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_b", i), 32'(tif.TC_B_wr_addr), 32'(vecs[i].exp_b));
      chk($sformatf("vec%0d_din", i), 32'(tif.TC_din), 32'(vecs[i].exp_din));
    end
    @(negedge clk);
    tif.tc_valid = 1'b0;
    @(posedge clk); #1;
    check_outputs_idle("vec_end");

    run_fill("mbfill", 1'b1, 1'b0, 2'd0, 8'd2, -1, 6'd0, 5'd0);
    run_fill("b8q2", 1'b0, 1'b0, 2'd2, 8'd9, -1, 6'd0, 5'd0);
    run_fill("both", 1'b1, 1'b1, 2'd3, 8'd127, -1, 6'd0, 5'd0);
    run_fill("skid", 1'b0, 1'b0, 2'd0, 8'd4, 4, 6'd12, 5'd3);
    run_fill("mbskid", 1'b1, 1'b0, 2'd0, 8'd7, 4, 6'd12, 5'd3);

    // Reset during the 10th fill write.
    @(negedge clk);
    tif.mb_num_h    = 8'd6;
    tif.mb_zero_req = 1'b1;
    @(posedge clk); #1;
    tif.mb_zero_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midfill_wr_n_pre", 32'(tif.TC_wr_n), 32'd0);
    chk("midfill_a_pre", 32'(tif.TC_A_wr_addr), 32'd9);
    reset_n = 1'b0;
    #1;
    check_outputs_idle("midfill_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_wr_n[%0d]", c), 32'(tif.TC_wr_n), 32'd1);
      chk($sformatf("post_rst_busy[%0d]", c), 32'(tif.busy), 32'd0);
    end

    @(negedge clk);
    tif.tc_valid   = 1'b1;
    tif.blk_idx    = 6'd7;
    tif.TotalCoeff = 5'd5;
    tif.res_0      = 1'b0;
    tif.mb_num_h   = 8'd1;
    @(posedge clk); #1;
    tif.tc_valid = 1'b0;
    chk("recover_wr_n", 32'(tif.TC_wr_n), 32'd0);
    chk("recover_a", 32'(tif.TC_A_wr_addr), 32'd7);
    chk("recover_b", 32'(tif.TC_B_wr_addr), 32'd71);
    chk("recover_din", 32'(tif.TC_din), 32'd5);
    @(posedge clk); #1;
    check_outputs_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
